// File: rtl/ref_read_arbiter.sv
// Round-robin arbiter sharing one DRAM reference reader between NUM_ENGINES engines.
// Grants one request, forwards it to the reader, then streams exactly `length` blocks back to the winner.
module ref_read_arbiter #(
   parameter int NUM_ENGINES = 4,
   parameter int REF_LENGTH  = 128,
   parameter int ADDR_W      = 25
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_ENGINES*ADDR_W-1:0]   eng_ref_addr_in,
   input  logic [NUM_ENGINES*ADDR_W-1:0]   eng_ref_length_in,
   input  logic [NUM_ENGINES-1:0]          eng_ref_info_valid_in,
   output logic [NUM_ENGINES-1:0]          eng_ref_info_rdy_out,
   output logic [2*REF_LENGTH-1:0]         eng_ref_seq_block_out,
   output logic [NUM_ENGINES-1:0]          eng_ref_seq_block_valid_out,
   input  logic [NUM_ENGINES-1:0]          eng_ref_seq_block_rdy_in,
   output logic [ADDR_W-1:0]               ref_addr_out,
   output logic [ADDR_W-1:0]               ref_length_out,
   output logic                            ref_info_valid_out,
   input  logic                            ref_info_rdy_in,
   input  logic [2*REF_LENGTH-1:0]         ref_seq_block_in,
   input  logic                            ref_seq_block_valid_in,
   output logic                            ref_seq_block_rdy_out,
   output logic [$clog2(NUM_ENGINES)-1:0]  grant_id_out,
   output logic                            busy_out
);

   localparam int GW = $clog2(NUM_ENGINES);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_e;

   state_e            state_q, state_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] remaining_q, remaining_d;

   logic              win_found;
   logic [GW-1:0]     win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic [ADDR_W-1:0] win_len;
   logic              grant_now;
   logic              blk_xfer;
   int                scan_idx;

   // Scan from last_grant+1 with wrap so every requester is reached within NUM_ENGINES grants.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int k = 1; k <= NUM_ENGINES; k++) begin
         scan_idx = (int'(last_grant_q) + k) % NUM_ENGINES;
         if (!win_found && eng_ref_info_valid_in[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = GW'(scan_idx);
         end
      end
   end

   assign win_addr  = eng_ref_addr_in[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_len   = eng_ref_length_in[int'(win_idx)*ADDR_W +: ADDR_W];
   assign grant_now = (state_q == S_IDLE) && win_found;
   assign blk_xfer  = (state_q == S_STREAM) && ref_seq_block_valid_in
                      && eng_ref_seq_block_rdy_in[grant_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (win_found && (win_len != '0)) state_d = S_ISSUE;
         S_ISSUE:  if (ref_info_rdy_in) state_d = S_STREAM;
         S_STREAM: if (blk_xfer && (remaining_q == ADDR_W'(1))) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      eng_ref_info_rdy_out        = '0;
      eng_ref_seq_block_valid_out = '0;
      ref_seq_block_rdy_out       = 1'b0;
      ref_info_valid_out          = (state_q == S_ISSUE);
      busy_out                    = (state_q != S_IDLE);
      if (grant_now) eng_ref_info_rdy_out[win_idx] = 1'b1;
      if (state_q == S_STREAM) begin
         eng_ref_seq_block_valid_out[grant_q] = ref_seq_block_valid_in;
         ref_seq_block_rdy_out                = eng_ref_seq_block_rdy_in[grant_q];
      end
   end

   // A zero-length request still updates the grant registers even though it is dropped.
   always_comb begin
      addr_d       = addr_q;
      len_d        = len_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      remaining_d  = remaining_q;
      if (grant_now) begin
         addr_d       = win_addr;
         len_d        = win_len;
         grant_d      = win_idx;
         last_grant_d = win_idx;
         remaining_d  = win_len;
      end else if (blk_xfer) begin
         remaining_d  = remaining_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= '0;
         len_q        <= '0;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_ENGINES - 1);
         remaining_q  <= '0;
      end else begin
         addr_q       <= addr_d;
         len_q        <= len_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         remaining_q  <= remaining_d;
      end
   end

   assign ref_addr_out          = addr_q;
   assign ref_length_out        = len_q;
   assign grant_id_out          = grant_q;
   assign eng_ref_seq_block_out = ref_seq_block_in;

endmodule

// File: tb/tb_ref_read_arbiter.sv
// Scoreboard bench for ref_read_arbiter: a reader model and engine drivers record observed
// grants, reader requests and block deliveries, which each scenario compares against its expectations.
module tb_ref_read_arbiter;

   localparam int N  = 4;
   localparam int RL = 128;
   localparam int AW = 25;
   localparam int BW = 2 * RL;
   localparam int GW = 2;

   typedef struct {
      int            kind;   // 0 grant, 1 reader request, 2 block delivery
      logic [N-1:0]  eng;
      logic [BW-1:0] val;
   } evt_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] req_addr, req_len;
   logic [N-1:0]    req_v, eng_rdy;
   logic            rd_info_rdy;
   logic [BW-1:0]   rd_blk;
   logic            rd_blk_v;

   logic [N-1:0]    eng_ref_info_rdy_out, eng_ref_seq_block_valid_out;
   logic [BW-1:0]   eng_ref_seq_block_out;
   logic [AW-1:0]   ref_addr_out, ref_length_out;
   logic            ref_info_valid_out, ref_seq_block_rdy_out, busy_out;
   logic [GW-1:0]   grant_id_out;

   ref_read_arbiter #(.NUM_ENGINES(N), .REF_LENGTH(RL), .ADDR_W(AW)) dut (
      .clk                         (clk),
      .rst                         (rst),
      .eng_ref_addr_in             (req_addr),
      .eng_ref_length_in           (req_len),
      .eng_ref_info_valid_in       (req_v),
      .eng_ref_info_rdy_out        (eng_ref_info_rdy_out),
      .eng_ref_seq_block_out       (eng_ref_seq_block_out),
      .eng_ref_seq_block_valid_out (eng_ref_seq_block_valid_out),
      .eng_ref_seq_block_rdy_in    (eng_rdy),
      .ref_addr_out                (ref_addr_out),
      .ref_length_out              (ref_length_out),
      .ref_info_valid_out          (ref_info_valid_out),
      .ref_info_rdy_in             (rd_info_rdy),
      .ref_seq_block_in            (rd_blk),
      .ref_seq_block_valid_in      (rd_blk_v),
      .ref_seq_block_rdy_out       (ref_seq_block_rdy_out),
      .grant_id_out                (grant_id_out),
      .busy_out                    (busy_out)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   evt_t exp_q[$];
   evt_t obs_q[$];

   // reader model
   int            rd_left;
   int            rd_idx;
   logic [AW-1:0] rd_addr;
   bit            rd_preload;

   // snapshot of DUT outputs taken mid-cycle by step()
   logic [N-1:0]  s_rdy, s_bv;
   logic          s_info_v, s_brdy;

   function automatic logic [BW-1:0] mkblk(input logic [AW-1:0] a, input int k);
      logic [BW-1:0] b;
      b = '0;
      b[AW+15:0] = {a, k[15:0]};
      b[BW-1:BW-8] = 8'hA5;
      return b;
   endfunction

   function automatic logic [BW-1:0] mkinfo(input int e, input logic [AW-1:0] a, input logic [AW-1:0] l);
      logic [BW-1:0] v;
      logic [31:0]   ev;
      v  = '0;
      ev = e;
      v[GW+2*AW-1:0] = {ev[GW-1:0], a, l};
      return v;
   endfunction

   function automatic logic [N-1:0] oh(input int e);
      logic [N-1:0] m;
      m = '0;
      m[e] = 1'b1;
      return m;
   endfunction

   task automatic set_req(input int e, input logic [AW-1:0] a, input logic [AW-1:0] l);
      req_addr[e*AW +: AW] = a;
      req_len[e*AW +: AW]  = l;
      req_v[e]             = 1'b1;
   endtask

   // Expected events for one request, in the order the arbiter must produce them.
   task automatic expect_req(input int e, input logic [AW-1:0] a, input int l);
      exp_q.push_back('{0, oh(e), '0});
      if (l != 0) begin
         exp_q.push_back('{1, '0, mkinfo(e, a, AW'(l))});
         for (int k = 0; k < l; k++) exp_q.push_back('{2, oh(e), mkblk(a, k)});
      end
   endtask

   // One clock: sample mid-cycle, log handshakes that complete at the next edge, then drive.
   task automatic step();
      logic [N-1:0] ack;
      @(negedge clk);
      s_rdy    = eng_ref_info_rdy_out;
      s_bv     = eng_ref_seq_block_valid_out;
      s_info_v = ref_info_valid_out;
      s_brdy   = ref_seq_block_rdy_out;
      ack      = s_rdy & req_v;
      if (s_rdy != '0) obs_q.push_back('{0, s_rdy, '0});
      if (ref_info_valid_out && rd_info_rdy) begin
         obs_q.push_back('{1, '0, mkinfo(int'(grant_id_out), ref_addr_out, ref_length_out)});
         if (!rd_preload) begin
            rd_addr = ref_addr_out;
            rd_left = int'(ref_length_out);
            rd_idx  = 0;
         end
         rd_preload = 1'b0;
      end
      if (rd_blk_v && ref_seq_block_rdy_out) begin
         obs_q.push_back('{2, eng_ref_seq_block_valid_out, eng_ref_seq_block_out});
         rd_idx++;
         rd_left--;
      end
      @(posedge clk);
      #1;
      req_v    = req_v & ~ack;
      rd_blk_v = (rd_left > 0);
      rd_blk   = mkblk(rd_addr, rd_idx);
   endtask

   task automatic drain(input int maxc, output int ncyc, output bit to);
      ncyc = 0;
      to   = 1'b1;
      for (int c = 0; c < maxc; c++) begin
         step();
         ncyc++;
         if (req_v == '0 && !busy_out && rd_left == 0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      req_v       = '0;
      req_addr    = '0;
      req_len     = '0;
      eng_rdy     = '1;
      rd_info_rdy = 1'b1;
      rd_left     = 0;
      rd_idx      = 0;
      rd_addr     = '0;
      rd_preload  = 1'b0;
      rd_blk_v    = 1'b0;
      rd_blk      = '0;
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({ref_addr_out, ref_length_out, grant_id_out} !== '0) begin
         failures++;
         $display("FAIL reset_regs addr=%h len=%h gid=%0d required all 0", ref_addr_out, ref_length_out, grant_id_out);
      end
      checks++;
      if ({busy_out, ref_info_valid_out, ref_seq_block_rdy_out, eng_ref_info_rdy_out, eng_ref_seq_block_valid_out} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl busy=%b info_v=%b blk_rdy=%b rdy=%b bv=%b required all 0", busy_out,
                  ref_info_valid_out, ref_seq_block_rdy_out, eng_ref_info_rdy_out, eng_ref_seq_block_valid_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int n; bit to; evt_t e, o;
      set_req(1, 25'h100, 25'd3);
      expect_req(1, 25'h100, 3);
      step();
      checks++;
      if (s_rdy !== 4'b0010 || s_info_v !== 1'b0) begin
         failures++;
         $display("FAIL single_grant rdy=%b info_v=%b required 0010/0", s_rdy, s_info_v);
      end
      step();
      checks++;
      if (s_rdy !== 4'b0000 || s_info_v !== 1'b1) begin
         failures++;
         $display("FAIL single_issue rdy=%b info_v=%b required 0000/1", s_rdy, s_info_v);
      end
      drain(50, n, to);
      checks++;
      if (to) begin failures++; $display("FAIL single_timeout busy=%b required 0", busy_out); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL single_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL single_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL single_extra count=%0d required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_round_robin();
      int n; bit to; evt_t e, o;
      apply_reset();
      rst = 1'b0;
      set_req(0, 25'h1000, 25'd2);
      set_req(1, 25'h2000, 25'd1);
      set_req(2, 25'h3000, 25'd3);
      set_req(3, 25'h4000, 25'd2);
      expect_req(0, 25'h1000, 2);
      expect_req(1, 25'h2000, 1);
      expect_req(2, 25'h3000, 3);
      expect_req(3, 25'h4000, 2);
      drain(100, n, to);
      checks++;
      if (to || n != 16) begin
         failures++;
         $display("FAIL rr_cycles got %0d timeout=%0d required 16", n, to);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL rr_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL rr_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL rr_extra count=%0d required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_backpressure();
      logic [3:0] pat;
      bit done; evt_t e, o;
      pat  = 4'b1001;
      done = 1'b0;
      set_req(2, 25'h2A0, 25'd4);
      expect_req(2, 25'h2A0, 4);
      for (int c = 0; c < 60 && !done; c++) begin
         eng_rdy[2] = pat[c % 4];
         step();
         if (s_bv[2]) begin
            checks++;
            if (s_brdy !== eng_rdy[2]) begin
               failures++;
               $display("FAIL bp_rdy cycle=%0d got %b required %b", c, s_brdy, eng_rdy[2]);
            end
         end
         done = (req_v == '0 && !busy_out && rd_left == 0);
      end
      eng_rdy = '1;
      checks++;
      if (!done) begin failures++; $display("FAIL bp_timeout busy=%b required 0", busy_out); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL bp_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL bp_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL bp_extra count=%0d required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_zero_len();
      int n; bit to; evt_t e, o;
      // last grant was engine 2, so engine 3 (zero length) wins before engine 0
      set_req(3, 25'h777, 25'd0);
      set_req(0, 25'h0A0, 25'd1);
      expect_req(3, 25'h777, 0);
      expect_req(0, 25'h0A0, 1);
      step();
      checks++;
      if (s_rdy !== 4'b1000) begin failures++; $display("FAIL zero_grant3 rdy=%b required 1000", s_rdy); end
      step();
      checks++;
      if (s_rdy !== 4'b0001 || s_info_v !== 1'b0) begin
         failures++;
         $display("FAIL zero_next rdy=%b info_v=%b required 0001/0", s_rdy, s_info_v);
      end
      drain(50, n, to);
      checks++;
      if (to) begin failures++; $display("FAIL zero_timeout busy=%b required 0", busy_out); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL zero_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL zero_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL zero_extra count=%0d required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_early_data();
      int n; bit to; evt_t e, o;
      rd_preload  = 1'b1;
      rd_addr     = 25'h3C0;
      rd_left     = 2;
      rd_idx      = 0;
      rd_blk_v    = 1'b1;
      rd_blk      = mkblk(25'h3C0, 0);
      rd_info_rdy = 1'b0;
      set_req(1, 25'h3C0, 25'd2);
      expect_req(1, 25'h3C0, 2);
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (s_brdy !== 1'b0 || s_bv !== '0 || (c > 0 && s_info_v !== 1'b1)) begin
            failures++;
            $display("FAIL early_stall cycle=%0d blk_rdy=%b bv=%b info_v=%b required 0/0000/%0d",
                     c, s_brdy, s_bv, s_info_v, (c > 0));
         end
      end
      rd_info_rdy = 1'b1;
      drain(50, n, to);
      checks++;
      if (to) begin failures++; $display("FAIL early_timeout busy=%b required 0", busy_out); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL early_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL early_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL early_extra count=%0d required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_reset_mid();
      int n; bit to; evt_t e, o;
      set_req(2, 25'h500, 25'd8);
      exp_q.push_back('{0, oh(2), '0});
      exp_q.push_back('{1, '0, mkinfo(2, 25'h500, 25'd8)});
      for (int k = 0; k < 3; k++) exp_q.push_back('{2, oh(2), mkblk(25'h500, k)});
      repeat (5) step();
      // three blocks delivered, remaining is now 5, reader still presenting data
      rst = 1'b1;
      #1;
      checks++;
      if ({ref_addr_out, ref_length_out, grant_id_out} !== '0) begin
         failures++;
         $display("FAIL mid_regs addr=%h len=%h gid=%0d required all 0", ref_addr_out, ref_length_out, grant_id_out);
      end
      checks++;
      if ({busy_out, ref_info_valid_out, ref_seq_block_rdy_out, eng_ref_info_rdy_out, eng_ref_seq_block_valid_out} !== '0) begin
         failures++;
         $display("FAIL mid_ctrl busy=%b info_v=%b blk_rdy=%b rdy=%b bv=%b required all 0", busy_out,
                  ref_info_valid_out, ref_seq_block_rdy_out, eng_ref_info_rdy_out, eng_ref_seq_block_valid_out);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL mid_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL mid_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      obs_q.delete();
      @(posedge clk);
      #1;
      rd_left  = 0;
      rd_blk_v = 1'b0;
      rst      = 1'b0;
      for (int i = 0; i < N; i++) begin
         set_req(i, AW'(32'h600 + i * 16), 25'd1);
         expect_req(i, AW'(32'h600 + i * 16), 1);
      end
      drain(60, n, to);
      checks++;
      if (to) begin failures++; $display("FAIL post_timeout busy=%b required 0", busy_out); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL post_missing kind=%0d eng=%b val=%h", e.kind, e.eng, e.val);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.eng !== e.eng || o.val !== e.val) begin
               failures++;
               $display("FAIL post_evt got kind=%0d eng=%b val=%h required kind=%0d eng=%b val=%h",
                        o.kind, o.eng, o.val, e.kind, e.eng, e.val);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL post_extra count=%0d required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_zero_len();
      test_early_data();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
